// File: rtl/param_load_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : param_load_sequencer_if
//  Description : Bundle between the host bridge / controller and the RNN
//                parameter load sequencer.
//                  start, in_valid, in_data         host -> sequencer
//                  in_ready                         sequencer -> host
//                  mat_write/seli/selj/data         sequencer -> matrix store
//                  vec_write/sel/data               sequencer -> vector store
//                  busy, done, err                  sequencer -> controller
//                The "slave" modport is the sequencer's view; "master" is the
//                host/controller view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface param_load_sequencer_if #(
    parameter int DW = 16
);
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    logic          mat_write;
    logic [1:0]    mat_seli;
    logic [3:0]    mat_selj;
    logic [DW-1:0] mat_data;

    logic          vec_write;
    logic [3:0]    vec_sel;
    logic [DW-1:0] vec_data;

    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, in_valid, in_data,
        input  in_ready,
        input  mat_write, mat_seli, mat_selj, mat_data,
        input  vec_write, vec_sel, vec_data,
        input  busy, done, err
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready,
        output mat_write, mat_seli, mat_selj, mat_data,
        output vec_write, vec_sel, vec_data,
        output busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/param_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : param_load_sequencer
//  Description : Feeds the RNN parameter stores from a valid/ready word
//                stream. After a start pulse the first ROWS*COLS words are
//                written to the matrix store in row-major order, the next
//                VLEN words to the vector store. Every store strobe appears
//                one cycle after the accepting edge. busy covers the load,
//                done pulses for one cycle when the parameters are resident.
//  Ports       : clk, reset (async, active-high)
//                bus.start/in_valid/in_data  in : load request, word stream
//                bus.in_ready                out: combinational accept enable
//                bus.mat_*                   out: matrix store strobes
//                bus.vec_*                   out: vector store strobes
//                bus.busy/done/err           out: status (registered)
//  Option      : PARAM_CHECKSUM_EN - one extra stream word after the vector
//                is compared with the mod-2^DW sum of all data words; err
//                reports a mismatch. Undefined: err is constant 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_load_sequencer #(
    parameter int ROWS = 2,
    parameter int COLS = 4,
    parameter int VLEN = 4,
    parameter int DW   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    param_load_sequencer_if.slave bus
);

    localparam logic [1:0] C_ROW_LAST = 2'(ROWS - 1);
    localparam logic [3:0] C_COL_LAST = 4'(COLS - 1);
    localparam logic [3:0] C_VEC_LAST = 4'(VLEN - 1);

`ifdef PARAM_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_MAT = 3'd1,
        ST_LOAD_VEC = 3'd2,
        ST_CHECK    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_MAT = 3'd1,
        ST_LOAD_VEC = 3'd2,
        ST_DONE     = 3'd4
    } state_t;
`endif

    state_t        state_q,     state_d;
    logic [1:0]    row_q,       row_d;
    logic [3:0]    col_q,       col_d;
    logic [3:0]    idx_q,       idx_d;
    logic          mat_write_q, mat_write_d;
    logic [1:0]    mat_seli_q,  mat_seli_d;
    logic [3:0]    mat_selj_q,  mat_selj_d;
    logic [DW-1:0] mat_data_q,  mat_data_d;
    logic          vec_write_q, vec_write_d;
    logic [3:0]    vec_sel_q,   vec_sel_d;
    logic [DW-1:0] vec_data_q,  vec_data_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;
`ifdef PARAM_CHECKSUM_EN
    logic [DW-1:0] sum_q,       sum_d;
    logic          err_q,       err_d;
`endif

    logic w_in_ready;
    logic w_accept;

`ifdef PARAM_CHECKSUM_EN
    assign w_in_ready = (state_q == ST_LOAD_MAT) || (state_q == ST_LOAD_VEC) ||
                        (state_q == ST_CHECK);
`else
    assign w_in_ready = (state_q == ST_LOAD_MAT) || (state_q == ST_LOAD_VEC);
`endif
    assign w_accept = bus.in_valid & w_in_ready;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        idx_d       = idx_q;
        // Strobes are single-cycle; select/data hold their last value.
        mat_write_d = 1'b0;
        mat_seli_d  = mat_seli_q;
        mat_selj_d  = mat_selj_q;
        mat_data_d  = mat_data_q;
        vec_write_d = 1'b0;
        vec_sel_d   = vec_sel_q;
        vec_data_d  = vec_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef PARAM_CHECKSUM_EN
        sum_d       = sum_q;
        err_d       = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD_MAT;
                    row_d   = 2'd0;
                    col_d   = 4'd0;
                    idx_d   = 4'd0;
                    busy_d  = 1'b1;
`ifdef PARAM_CHECKSUM_EN
                    sum_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end

            ST_LOAD_MAT: begin
                if (w_accept) begin
                    mat_write_d = 1'b1;
                    mat_seli_d  = row_q;
                    mat_selj_d  = col_q;
                    mat_data_d  = bus.in_data;
`ifdef PARAM_CHECKSUM_EN
                    sum_d       = sum_q + bus.in_data;
`endif
                    if (col_q == C_COL_LAST) begin
                        col_d = 4'd0;
                        if (row_q == C_ROW_LAST) begin
                            row_d   = 2'd0;
                            state_d = ST_LOAD_VEC;
                        end else begin
                            row_d = row_q + 2'd1;
                        end
                    end else begin
                        col_d = col_q + 4'd1;
                    end
                end
            end

            ST_LOAD_VEC: begin
                if (w_accept) begin
                    vec_write_d = 1'b1;
                    vec_sel_d   = idx_q;
                    vec_data_d  = bus.in_data;
`ifdef PARAM_CHECKSUM_EN
                    sum_d       = sum_q + bus.in_data;
`endif
                    if (idx_q == C_VEC_LAST) begin
                        idx_d = 4'd0;
`ifdef PARAM_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        // done/busy land in the same cycle as the last write.
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end

`ifdef PARAM_CHECKSUM_EN
            ST_CHECK: begin
                // The compare word is consumed without any store write.
                if (w_accept) begin
                    err_d   = (bus.in_data != sum_q);
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif

            ST_DONE: begin
                // start is deliberately ignored here.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            row_q       <= 2'd0;
            col_q       <= 4'd0;
            idx_q       <= 4'd0;
            mat_write_q <= 1'b0;
            mat_seli_q  <= 2'd0;
            mat_selj_q  <= 4'd0;
            mat_data_q  <= '0;
            vec_write_q <= 1'b0;
            vec_sel_q   <= 4'd0;
            vec_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef PARAM_CHECKSUM_EN
            sum_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            idx_q       <= idx_d;
            mat_write_q <= mat_write_d;
            mat_seli_q  <= mat_seli_d;
            mat_selj_q  <= mat_selj_d;
            mat_data_q  <= mat_data_d;
            vec_write_q <= vec_write_d;
            vec_sel_q   <= vec_sel_d;
            vec_data_q  <= vec_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef PARAM_CHECKSUM_EN
            sum_q       <= sum_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mat_write = mat_write_q;
    assign bus.mat_seli  = mat_seli_q;
    assign bus.mat_selj  = mat_selj_q;
    assign bus.mat_data  = mat_data_q;
    assign bus.vec_write = vec_write_q;
    assign bus.vec_sel   = vec_sel_q;
    assign bus.vec_data  = vec_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
`ifdef PARAM_CHECKSUM_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_load_sequencer
//  Description : Self-checking bench for param_load_sequencer: a hand-written
//                vector table for one complete load, directed corner-case
//                sequences and randomized traffic checked against a
//                word-count based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_load_sequencer;

    localparam int ROWS   = 2;
    localparam int COLS   = 4;
    localparam int VLEN   = 4;
    localparam int DW     = 16;
    localparam int N_MAT  = ROWS * COLS;
    localparam int N_DATA = N_MAT + VLEN;
`ifdef PARAM_CHECKSUM_EN
    localparam int N_WORDS = N_DATA + 1;
`else
    localparam int N_WORDS = N_DATA;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    param_load_sequencer_if #(.DW(DW)) bus ();

    param_load_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .VLEN(VLEN), .DW(DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (word-count view of a load) ----------
    bit          m_loading;     // words are being accepted
    bit          m_done_cycle;  // current cycle is the done cycle
    int          m_k;           // words accepted in this load
    logic [15:0] m_sum;
    bit          e_mw, e_vw, e_busy, e_done, e_err;
    int          e_seli, e_selj, e_vsel;
    logic [15:0] e_mdata, e_vdata;

    task automatic model_reset();
        m_loading = 0; m_done_cycle = 0; m_k = 0; m_sum = '0;
        e_mw = 0; e_vw = 0; e_busy = 0; e_done = 0; e_err = 0;
        e_seli = 0; e_selj = 0; e_vsel = 0; e_mdata = '0; e_vdata = '0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(m_loading));
        chk({tag, ".mat"}, 64'({bus.mat_write, bus.mat_seli, bus.mat_selj, bus.mat_data}),
                           64'({e_mw, e_seli[1:0], e_selj[3:0], e_mdata}));
        chk({tag, ".vec"}, 64'({bus.vec_write, bus.vec_sel, bus.vec_data}),
                           64'({e_vw, e_vsel[3:0], e_vdata}));
        chk({tag, ".status"}, 64'({bus.busy, bus.done, bus.err}),
                              64'({e_busy, e_done, e_err}));
    endtask

    // Drive one cycle from a negedge, predict the edge, check at next negedge.
    task automatic cycle(input bit st, input bit v, input logic [15:0] d);
        bit acc;
        bus.start = st; bus.in_valid = v; bus.in_data = d;
        acc  = v && m_loading;
        e_mw = 0; e_vw = 0; e_done = 0;
        if (m_done_cycle) begin
            m_done_cycle = 0;
        end else if (!m_loading) begin
            if (st) begin
                m_loading = 1; m_k = 0; m_sum = '0; e_err = 0; e_busy = 1;
            end
        end else if (acc) begin
            if (m_k < N_MAT) begin
                e_mw = 1; e_seli = m_k / COLS; e_selj = m_k % COLS; e_mdata = d;
            end else if (m_k < N_DATA) begin
                e_vw = 1; e_vsel = m_k - N_MAT; e_vdata = d;
            end else begin
                e_err = (d != m_sum);
            end
            if (m_k < N_DATA) m_sum = m_sum + d;
            m_k++;
            if (m_k == N_WORDS) begin
                m_loading = 0; m_done_cycle = 1; e_done = 1; e_busy = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs("model");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.start = 0; bus.in_valid = 0; bus.in_data = '0;
        #2;
        model_reset();
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Feed words 1,2,3... (checksum word csum) until stop_k words or load end.
    task automatic feed(input bit toggle, input logic [15:0] csum, input int stop_k);
        int c = 0;
        while (m_loading && m_k < stop_k && c < 200) begin
            cycle(1'b0, toggle ? c[0] : 1'b1,
                  (m_k < N_DATA) ? 16'(m_k + 1) : csum);
            c++;
        end
    endtask

    // ---------------- vector table: one load, hand-derived expectations ----
    typedef struct {
        bit st; bit v; logic [15:0] d;
        bit rdy;
        bit mw; int seli; int selj; logic [15:0] md;
        bit vw; int vs; logic [15:0] vd;
        bit busy; bit done; bit err;
    } vec_t;
    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 0; bus.in_valid = 0; bus.in_data = '0;
        //                st v d        rdy mw si sj md  vw vs vd  bsy dn er
        tbl.push_back('{1, 0, 16'h0000, 1,  0, 0, 0, 0,  0, 0, 0,  1,  0, 0});
        tbl.push_back('{0, 1, 16'h0001, 1,  1, 0, 0, 1,  0, 0, 0,  1,  0, 0});
        tbl.push_back('{0, 1, 16'h0002, 1,  1, 0, 1, 2,  0, 0, 0,  1,  0, 0});
        tbl.push_back('{0, 1, 16'h0003, 1,  1, 0, 2, 3,  0, 0, 0,  1,  0, 0});
        tbl.push_back('{0, 1, 16'h0004, 1,  1, 0, 3, 4,  0, 0, 0,  1,  0, 0});
        tbl.push_back('{0, 1, 16'h0005, 1,  1, 1, 0, 5,  0, 0, 0,  1,  0, 0});
        tbl.push_back('{0, 1, 16'h0006, 1,  1, 1, 1, 6,  0, 0, 0,  1,  0, 0});
        tbl.push_back('{0, 1, 16'h0007, 1,  1, 1, 2, 7,  0, 0, 0,  1,  0, 0});
        tbl.push_back('{0, 1, 16'h0008, 1,  1, 1, 3, 8,  0, 0, 0,  1,  0, 0});
        tbl.push_back('{0, 1, 16'h0009, 1,  0, 1, 3, 8,  1, 0, 9,  1,  0, 0});
        tbl.push_back('{0, 1, 16'h000A, 1,  0, 1, 3, 8,  1, 1, 10, 1,  0, 0});
        tbl.push_back('{0, 1, 16'h000B, 1,  0, 1, 3, 8,  1, 2, 11, 1,  0, 0});
`ifdef PARAM_CHECKSUM_EN
        tbl.push_back('{0, 1, 16'h000C, 1,  0, 1, 3, 8,  1, 3, 12, 1,  0, 0});
        tbl.push_back('{0, 1, 16'h004E, 0,  0, 1, 3, 8,  0, 3, 12, 0,  1, 0});
`else
        tbl.push_back('{0, 1, 16'h000C, 0,  0, 1, 3, 8,  1, 3, 12, 0,  1, 0});
`endif
        tbl.push_back('{0, 1, 16'hAAAA, 0,  0, 1, 3, 8,  0, 3, 12, 0,  0, 0});
        tbl.push_back('{0, 1, 16'hAAAA, 0,  0, 1, 3, 8,  0, 3, 12, 0,  0, 0});

        @(negedge clk);
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            bus.start = tbl[i].st; bus.in_valid = tbl[i].v; bus.in_data = tbl[i].d;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl[%0d].in_ready", i), 64'(bus.in_ready), 64'(tbl[i].rdy));
            chk($sformatf("tbl[%0d].mat", i),
                64'({bus.mat_write, bus.mat_seli, bus.mat_selj, bus.mat_data}),
                64'({tbl[i].mw, tbl[i].seli[1:0], tbl[i].selj[3:0], tbl[i].md}));
            chk($sformatf("tbl[%0d].vec", i),
                64'({bus.vec_write, bus.vec_sel, bus.vec_data}),
                64'({tbl[i].vw, tbl[i].vs[3:0], tbl[i].vd}));
            chk($sformatf("tbl[%0d].status", i),
                64'({bus.busy, bus.done, bus.err}),
                64'({tbl[i].busy, tbl[i].done, tbl[i].err}));
        end

        // Full load with valid held high, then valid in IDLE without start.
        do_reset();
        cycle(1'b1, 1'b0, 16'h0);
        feed(1'b0, 16'h004E, 99);
        repeat (3) cycle(1'b0, 1'b1, 16'hAAAA);

        // Same stream with valid toggling.
        cycle(1'b1, 1'b0, 16'h0);
        feed(1'b1, 16'h004E, 99);
        cycle(1'b0, 1'b0, 16'h0);

        // start during LOAD_MAT and in the DONE cycle is ignored; the next
        // IDLE-cycle start begins a fresh load at (0,0).
        cycle(1'b1, 1'b0, 16'h0);
        feed(1'b0, 16'h004E, 3);
        cycle(1'b1, 1'b1, 16'h0004);
        feed(1'b0, 16'h004E, 99);
        cycle(1'b1, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 16'h1234);
        feed(1'b0, 16'h004E, 99);
        cycle(1'b0, 1'b0, 16'h0);

        // Reset after the fifth accepted word, then a complete reload.
        cycle(1'b1, 1'b0, 16'h0);
        feed(1'b0, 16'h004E, 5);
        do_reset();
        repeat (2) cycle(1'b0, 1'b1, 16'h5555);
        cycle(1'b1, 1'b0, 16'h0);
        feed(1'b0, 16'h004E, 99);
        cycle(1'b0, 1'b0, 16'h0);

        // Bad checksum: err holds through IDLE until the next start.
        cycle(1'b1, 1'b0, 16'h0);
        feed(1'b0, 16'h004F, 99);
        repeat (3) cycle(1'b0, 1'b1, 16'hAAAA);
        cycle(1'b1, 1'b0, 16'h0);
        feed(1'b0, 16'h004E, 99);
        cycle(1'b0, 1'b0, 16'h0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if (m_loading && m_k == N_DATA && $urandom_range(0, 1) == 1) d = m_sum;
            if ($urandom_range(0, 299) == 0)
                do_reset();
            else
                cycle($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
